// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared widths, zigzag scan order and reciprocal quantization tables.
//   ZIGZAG_LUT[k]    raster index (row*8+col) of zigzag position k
//   QRECIP_LUMA/CHROMA[i]  round(65536/Q[i]) for the Annex K quality-50 tables
package jpeg_pkg;
   localparam int COEF_WIDTH = 32;
   localparam int Q_WIDTH = 16;
   localparam int OUT_WIDTH = 12;
   localparam int SCALE_SHIFT = 32;
   localparam logic [OUT_WIDTH-1:0] QMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;
   typedef logic [63:0][Q_WIDTH-1:0] recip_t;
   localparam logic [5:0] ZIGZAG_LUT [64] = '{
      0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
   localparam int QTAB_LUMA [64] = '{
      16, 11, 10, 16, 24, 40, 51, 61,
      12, 12, 14, 19, 26, 58, 60, 55,
      14, 13, 16, 24, 40, 57, 69, 56,
      14, 17, 22, 29, 51, 87, 80, 62,
      18, 22, 37, 56, 68, 109, 103, 77,
      24, 35, 55, 64, 81, 104, 113, 92,
      49, 64, 78, 87, 103, 121, 120, 101,
      72, 92, 95, 98, 112, 100, 103, 99};
   localparam int QTAB_CHROMA [64] = '{
      17, 18, 24, 47, 99, 99, 99, 99,
      18, 21, 26, 66, 99, 99, 99, 99,
      24, 26, 56, 99, 99, 99, 99, 99,
      47, 66, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99};
   // Evaluated at elaboration only; turns the Q tables into rounded reciprocals.
   function automatic recip_t build_recip(input logic chroma);
      recip_t t;
      for (int i = 0; i < 64; i++) begin
         int q;
         q = chroma ? QTAB_CHROMA[i] : QTAB_LUMA[i];
         t[i] = Q_WIDTH'((65536 + q / 2) / q);
      end
      return t;
   endfunction
   localparam recip_t QRECIP_LUMA = build_recip(1'b0);
   localparam recip_t QRECIP_CHROMA = build_recip(1'b1);
endpackage

// File: rtl/quant_mul.sv
// quant_mul: one coefficient times reciprocal, rounded half away from zero, saturated to +/-QMAX.
//   coef   in   signed DCT coefficient
//   recip  in   unsigned reciprocal round(65536/Q)
//   q      out  signed quantized value
module quant_mul
   import jpeg_pkg::*;
(
   input  logic [COEF_WIDTH-1:0] coef,
   input  logic [Q_WIDTH-1:0]    recip,
   output logic [OUT_WIDTH-1:0]  q
);
   localparam int PW = COEF_WIDTH + Q_WIDTH + 2;
   localparam int MW = PW - SCALE_SHIFT;
   logic [COEF_WIDTH:0]    mag;
   logic [MW-1:0]          mq;
   logic [OUT_WIDTH-1:0]   m;
   always_comb begin
      // Extra magnitude bit keeps -2^31 from wrapping back to itself.
      mag = coef[COEF_WIDTH-1] ? ~{1'b1, coef} + (COEF_WIDTH+1)'(1) : {1'b0, coef};
      mq = MW'((PW'(mag) * PW'(recip) + (PW'(1) << (SCALE_SHIFT - 1))) >> SCALE_SHIFT);
      m = (|mq[MW-1:OUT_WIDTH-1]) ? QMAX : {1'b0, mq[OUT_WIDTH-2:0]};
      q = coef[COEF_WIDTH-1] ? ~m + OUT_WIDTH'(1) : m;
   end
endmodule

// File: rtl/quant_zigzag.sv
// quant_zigzag: quantizes DCT rows into a ping-pong block buffer and drains blocks in zigzag order.
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   row_valid_i        row beat valid; row_data_i {c7..c0}; qtab_sel_i 0 luma / 1 chroma (beat 0)
//   in_ready_o         write bank free; beats while low are dropped and set overflow_o (sticky)
//   coef_o/coef_idx_o  quantized coefficient and its zigzag index, coef_last_o on index 63
//   coef_valid_o/coef_ready_i  output handshake
module quant_zigzag
   import jpeg_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    row_valid_i,
   input  logic [8*COEF_WIDTH-1:0] row_data_i,
   input  logic                    qtab_sel_i,
   output logic                    in_ready_o,
   output logic [OUT_WIDTH-1:0]    coef_o,
   output logic [5:0]              coef_idx_o,
   output logic                    coef_last_o,
   output logic                    coef_valid_o,
   input  logic                    coef_ready_i,
   output logic                    overflow_o
);
   rd_state_t state, nxt;
   logic [2:0] row, p_row;
   logic wr_bank, wr_bank_nxt, rd_bank, qsel, sel, accept, blk_done;
   logic p_valid, p_bank, load, free, ld_bank;
   logic [1:0] full, full_nxt;
   logic [5:0] ld_k;
   logic [OUT_WIDTH-1:0] q [8];
   logic [OUT_WIDTH-1:0] p_q [8];
   logic [OUT_WIDTH-1:0] bank [2][64];
   logic [OUT_WIDTH-1:0] rd_data;
   assign accept = row_valid_i && in_ready_o;
   assign sel = (row == 3'd0) ? qtab_sel_i : qsel;
   assign blk_done = p_valid && (p_row == 3'd7);
   // The write bank flips as soon as beat 7 is taken so the next block can stream in
   // back to back; the finished bank is marked full once its last row leaves the pipeline.
   assign wr_bank_nxt = wr_bank ^ (accept && (row == 3'd7));
   assign rd_data = bank[ld_bank][ZIGZAG_LUT[ld_k]];
   for (genvar i = 0; i < 8; i++) begin : g_lane
      quant_mul u_mul (
         .coef (row_data_i[i*COEF_WIDTH +: COEF_WIDTH]),
         .recip(sel ? QRECIP_CHROMA[{row, 3'(i)}] : QRECIP_LUMA[{row, 3'(i)}]),
         .q    (q[i])
      );
   end
   always_comb begin
      nxt = state;
      load = 1'b0;
      free = 1'b0;
      ld_bank = rd_bank;
      ld_k = '0;
      if (state == RD_IDLE) begin
         load = full[rd_bank];
         nxt = full[rd_bank] ? RD_DRAIN : RD_IDLE;
      end else if (coef_ready_i) begin
         // Last coefficient taken: release the bank and chain straight into the other one if ready.
         free = coef_last_o;
         ld_bank = rd_bank ^ coef_last_o;
         ld_k = coef_last_o ? 6'd0 : coef_idx_o + 6'd1;
         load = !coef_last_o || full[~rd_bank];
         nxt = load ? RD_DRAIN : RD_IDLE;
      end
   end
   always_comb begin
      full_nxt = full;
      if (blk_done) full_nxt[p_bank] = 1'b1;
      if (free) full_nxt[rd_bank] = 1'b0;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= RD_IDLE;
         full <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         row <= '0;
         qsel <= 1'b0;
         in_ready_o <= 1'b1;
         overflow_o <= 1'b0;
         p_valid <= 1'b0;
         p_row <= '0;
         p_bank <= 1'b0;
         coef_o <= '0;
         coef_idx_o <= '0;
         coef_last_o <= 1'b0;
         coef_valid_o <= 1'b0;
      end else begin
         state <= nxt;
         full <= full_nxt;
         wr_bank <= wr_bank_nxt;
         rd_bank <= rd_bank ^ free;
         in_ready_o <= !full_nxt[wr_bank_nxt];
         overflow_o <= overflow_o | (row_valid_i & !in_ready_o);
         p_valid <= accept;
         if (accept) begin
            row <= row + 3'd1;
            p_row <= row;
            p_bank <= wr_bank;
            if (row == 3'd0) qsel <= qtab_sel_i;
         end
         if (load) begin
            coef_o <= rd_data;
            coef_idx_o <= ld_k;
            coef_last_o <= &ld_k;
         end
         coef_valid_o <= (nxt == RD_DRAIN);
      end
   end
   always_ff @(posedge clk_i) begin
      if (accept) p_q <= q;
      if (p_valid) for (int c = 0; c < 8; c++) bank[p_bank][{p_row, 3'(c)}] <= p_q[c];
   end
endmodule

// File: tb/tb_quant_zigzag.sv
// tb_quant_zigzag: table-driven and scoreboard bench for quant_zigzag.
module tb_quant_zigzag;
   logic clk = 0, rst_n = 0, row_valid = 0, qtab_sel = 0, coef_ready = 1;
   logic [255:0] row_data = '0;
   logic in_ready, coef_last, coef_valid, overflow;
   logic [11:0] coef;
   logic [5:0] coef_idx;
   always #5 clk = ~clk;
   quant_zigzag dut (
      .clk_i(clk), .rst_n_i(rst_n), .row_valid_i(row_valid), .row_data_i(row_data),
      .qtab_sel_i(qtab_sel), .in_ready_o(in_ready), .coef_o(coef), .coef_idx_o(coef_idx),
      .coef_last_o(coef_last), .coef_valid_o(coef_valid), .coef_ready_i(coef_ready),
      .overflow_o(overflow)
   );
   typedef struct {int coef; int idx;} exp_t;
   typedef struct {int c; bit fill; bit sel; int exp0;} vec_t;
   exp_t sb[$];
   int checks = 0, errors = 0;
   int zz[64];
   int blk[64];
   int ql[64] = '{16, 11, 10, 16, 24, 40, 51, 61, 12, 12, 14, 19, 26, 58, 60, 55,
                  14, 13, 16, 24, 40, 57, 69, 56, 14, 17, 22, 29, 51, 87, 80, 62,
                  18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
                  49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
   int qc[64] = '{17, 18, 24, 47, 99, 99, 99, 99, 18, 21, 26, 66, 99, 99, 99, 99,
                  24, 26, 56, 99, 99, 99, 99, 99, 47, 66, 99, 99, 99, 99, 99, 99,
                  99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99,
                  99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99};
   vec_t vecs[10] = '{
      '{1048576, 0, 0, 1}, '{-1048576, 0, 0, -1}, '{1572864, 0, 0, 2}, '{-1572864, 0, 0, -2},
      '{1638400, 0, 0, 2}, '{1638400, 0, 1, 1}, '{32'h7FFFFFFF, 1, 0, 2047},
      '{32'h80000000, 1, 0, -2047}, '{32'h7FFFFFFF, 1, 1, 1927}, '{32'h80000000, 1, 1, -1928}};
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask
   function automatic int model_q(int c, bit sel, int i);
      longint q, r, m, v;
      q = sel ? qc[i] : ql[i];
      r = (65536 + q / 2) / q;
      m = (c < 0) ? -longint'(c) : longint'(c);
      v = (m * r + (longint'(1) << 31)) >>> 32;
      if (v > 2047) v = 2047;
      return int'((c < 0) ? -v : v);
   endfunction
   function automatic void build_zz();
      int k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 7) ? s : 7;
         if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + s - r; k++; end
         else for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + s - r; k++; end
      end
   endfunction
   task automatic send_block(input bit sel);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) row_data[c*32 +: 32] = blk[r*8+c];
         row_valid = 1;
         qtab_sel = (r == 0) ? sel : !sel;
         @(posedge clk); #1;
      end
      row_valid = 0;
      row_data = '0;
   endtask
   task automatic push_model(input bit sel);
      for (int k = 0; k < 64; k++) sb.push_back('{model_q(blk[zz[k]], sel, zz[k]), k});
   endtask
   task automatic rand_block();
      for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 1 << 25)) - (1 << 24);
   endtask
   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin @(negedge clk); n++; end
      chk("drain_remaining", sb.size(), 0);
      @(negedge clk);
      chk("idle_valid", int'(coef_valid), 0);
   endtask
   task automatic wait_idx(input int target);
      int n = 0;
      @(negedge clk);
      while (!(coef_valid && coef_idx == target) && n < 300) begin @(negedge clk); n++; end
      chk("reach_idx", int'(coef_valid && coef_idx == target), 1);
   endtask
   always @(negedge clk) begin
      if (rst_n && coef_valid && coef_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got idx %0d coef %0d want none", coef_idx, $signed(coef));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("coef", int'($signed(coef)), e.coef);
            chk("idx", int'(coef_idx), e.idx);
            chk("last", int'(coef_last), int'(e.idx == 63));
         end
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      build_zz();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_valid", int'(coef_valid), 0);
      chk("rst_last", int'(coef_last), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_coef", int'(coef), 0);
      chk("rst_idx", int'(coef_idx), 0);
      rst_n = 1;
      @(posedge clk); #1;
      for (int v = 0; v < 10; v++) begin
         for (int i = 0; i < 64; i++) blk[i] = (vecs[v].fill || i == 0) ? vecs[v].c : 0;
         for (int k = 0; k < 64; k++)
            sb.push_back('{(zz[k] == 0) ? vecs[v].exp0 :
                           (vecs[v].fill ? model_q(vecs[v].c, vecs[v].sel, zz[k]) : 0), k});
         send_block(vecs[v].sel);
         if (v == 0) begin
            @(negedge clk);
            chk("lat_T", int'(coef_valid), 0);
            @(negedge clk);
            chk("lat_T1", int'(coef_valid), 0);
            @(negedge clk);
            chk("lat_T2_valid", int'(coef_valid), 1);
            chk("lat_T2_idx", int'(coef_idx), 0);
         end
         wait_drain();
      end
      for (int i = 0; i < 64; i++) blk[i] = i * ql[i] * 65536;
      for (int k = 0; k < 64; k++) sb.push_back('{zz[k], k});
      send_block(0);
      wait_drain();
      rand_block();
      push_model(1);
      send_block(1);
      wait_idx(4);
      @(posedge clk); #1;
      coef_ready = 0;
      repeat (10) begin
         @(negedge clk);
         chk("stall_valid", int'(coef_valid), 1);
         chk("stall_idx", int'(coef_idx), 5);
         chk("stall_coef", int'($signed(coef)), sb[0].coef);
      end
      @(posedge clk); #1;
      coef_ready = 1;
      wait_drain();
      rand_block();
      push_model(0);
      send_block(0);
      rand_block();
      push_model(1);
      send_block(1);
      chk("b2b_in_ready_low", int'(in_ready), 0);
      chk("b2b_no_overflow_yet", int'(overflow), 0);
      rand_block();
      send_block(0);
      chk("b2b_overflow", int'(overflow), 1);
      chk("b2b_in_ready_still_low", int'(in_ready), 0);
      wait_drain();
      chk("b2b_in_ready_free", int'(in_ready), 1);
      chk("b2b_overflow_sticky", int'(overflow), 1);
      rand_block();
      push_model(0);
      send_block(0);
      wait_idx(30);
      rst_n = 0;
      #1;
      sb.delete();
      chk("mid_rst_valid", int'(coef_valid), 0);
      chk("mid_rst_idx", int'(coef_idx), 0);
      chk("mid_rst_coef", int'(coef), 0);
      chk("mid_rst_last", int'(coef_last), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_overflow", int'(overflow), 0);
      @(posedge clk); #1;
      chk("mid_rst_edge_valid", int'(coef_valid), 0);
      rst_n = 1;
      repeat (2) @(posedge clk);
      #1;
      rand_block();
      push_model(1);
      send_block(1);
      wait_drain();
      chk("final_overflow", int'(overflow), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
